dot_tile_ctrl: RTL and testbench

DOT_TILE_CTRL -- requirements
Module: dot_tile_ctrl

---
 rtl/dot_tile_ctrl.sv | 111 +++++++++++
 tb/tb_dot_tile_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_tile_ctrl.sv
// rtl/dot_tile_ctrl.sv - tile-streaming dot-product controller
// Fetches ceil(len/N) operand tiles, masks the tail, accumulates engine sums and returns the result.
module dot_tile_ctrl #(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 10,
  parameter int ADDR_W = 12
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic        [LEN_W-1:0]            len,
  input  logic        [ADDR_W-1:0]           a_base,
  input  logic        [ADDR_W-1:0]           b_base,
  output logic                               busy,
  output logic                               rd_en,
  output logic        [ADDR_W-1:0]           rd_a_addr,
  output logic        [ADDR_W-1:0]           rd_b_addr,
  input  logic signed [N-1:0][WIDTH-1:0]     rd_a_data,
  input  logic signed [N-1:0][WIDTH-1:0]     rd_b_data,
  output logic signed [N-1:0][WIDTH-1:0]     eng_a,
  output logic signed [N-1:0][WIDTH-1:0]     eng_b,
  input  logic signed [WIDTH-1:0]            eng_result,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic signed [ACC_W-1:0]            res_data
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [LEN_W-1:0]        len_q;
  logic [ADDR_W-1:0]       a_addr, b_addr;
  logic [LEN_W:0]          fidx;
  logic [LEN_W:0]          didx;
  logic                    dvalid;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic                    accept;
  logic                    last_tile;

  assign accept    = (state == IDLE) && start;
  // fidx is the element index of lane 0 of the tile being issued this cycle
  assign last_tile = ({1'b0, fidx} + (LEN_W+2)'(N)) >= {2'b0, len_q};
  assign ext       = {{(ACC_W-WIDTH){eng_result[WIDTH-1]}}, eng_result};
  assign rd_a_addr = a_addr;
  assign rd_b_addr = b_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      len_q  <= '0;
      a_addr <= '0;
      b_addr <= '0;
      fidx   <= '0;
      didx   <= '0;
      dvalid <= 1'b0;
      acc    <= '0;
    end else begin
      state  <= state_nx;
      dvalid <= rd_en;
      if (accept) begin
        len_q  <= len;
        a_addr <= a_base;
        b_addr <= b_base;
        fidx   <= '0;
      end else if (rd_en) begin
        a_addr <= a_addr + 1'b1;
        b_addr <= b_addr + 1'b1;
        fidx   <= fidx + (LEN_W+1)'(N);
        didx   <= fidx;
      end
      if (accept)
        acc <= '0;
      else if (dvalid)
        acc <= acc + ext;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    rd_en     = (state == FETCH);
    res_valid = (state == DONE);
    res_data  = '0;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : FETCH;
      FETCH:   if (last_tile) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE: begin
        res_data = acc;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lanes past the end of the vector are zeroed so stale memory never reaches the engine
  always_comb begin
    eng_a = '0;
    eng_b = '0;
    for (int i = 0; i < N; i++) begin
      if (dvalid && (({1'b0, didx} + (LEN_W+2)'(i)) < {2'b0, len_q})) begin
        eng_a[i] = rd_a_data[i];
        eng_b[i] = rd_b_data[i];
      end
    end
  end

endmodule

// File: tb/tb_dot_tile_ctrl.sv
// tb/tb_dot_tile_ctrl.sv - directed and random jobs against dot_tile_ctrl with a result scoreboard
module tb_dot_tile_ctrl;
  localparam int N = 4, WIDTH = 16, ACC_W = 32, LEN_W = 10, ADDR_W = 12;
  localparam int DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic res_ready = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [ADDR_W-1:0] a_base = '0, b_base = '0;
  logic busy, rd_en, res_valid;
  logic [ADDR_W-1:0] rd_a_addr, rd_b_addr;
  logic signed [N-1:0][WIDTH-1:0] rd_a_data, rd_b_data, eng_a, eng_b;
  logic signed [WIDTH-1:0] eng_result;
  logic signed [ACC_W-1:0] res_data;

  logic [N-1:0][WIDTH-1:0] mem_a [DEPTH];
  logic [N-1:0][WIDTH-1:0] mem_b [DEPTH];
  logic signed [2*WIDTH+7:0] esum;
  logic [ADDR_W-1:0] cap_a [64];
  logic [ADDR_W-1:0] cap_b [64];
  int rd_cnt = 0;
  int passed = 0, total = 0;
  longint exp_q[$];

  dot_tile_ctrl #(.N(N), .WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .a_base(a_base), .b_base(b_base),
    .busy(busy), .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data), .eng_a(eng_a), .eng_b(eng_b),
    .eng_result(eng_result), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      rd_a_data <= mem_a[rd_a_addr];
      rd_b_data <= mem_b[rd_b_addr];
    end
  end

  always_comb begin
    esum = '0;
    for (int i = 0; i < N; i++) esum = esum + $signed(eng_a[i]) * $signed(eng_b[i]);
    eng_result = esum[WIDTH-1:0];
  end

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      cap_a[rd_cnt % 64] <= rd_a_addr;
      cap_b[rd_cnt % 64] <= rd_b_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic longint model(input int l, input int ab, input int bb);
    logic signed [ACC_W-1:0] acc;
    logic signed [2*WIDTH+7:0] s;
    int t;
    acc = '0;
    t = (l + N - 1) / N;
    for (int k = 0; k < t; k++) begin
      s = '0;
      for (int i = 0; i < N; i++)
        if (k * N + i < l)
          s = s + $signed(mem_a[(ab + k) % DEPTH][i]) * $signed(mem_b[(bb + k) % DEPTH][i]);
      acc = acc + {{(ACC_W-WIDTH){s[WIDTH-1]}}, s[WIDTH-1:0]};
    end
    return acc;
  endfunction

  task automatic set_tile(input int addr, input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    mem_a[addr][0] = 16'(a0); mem_a[addr][1] = 16'(a1);
    mem_a[addr][2] = 16'(a2); mem_a[addr][3] = 16'(a3);
    mem_b[addr][0] = 16'(b0); mem_b[addr][1] = 16'(b1);
    mem_b[addr][2] = 16'(b2); mem_b[addr][3] = 16'(b3);
  endtask

  // Starts a job and waits for res_valid; leaves the bench in the first res_valid cycle
  task automatic run_job(input string tag, input int l, input int ab, input int bb);
    int c0, c, t, lat;
    t = (l + N - 1) / N;
    lat = (t == 0) ? 1 : t + 2;
    exp_q.push_back(model(l, ab, bb));
    c0 = rd_cnt;
    start = 1'b1; len = LEN_W'(l); a_base = ADDR_W'(ab); b_base = ADDR_W'(bb);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    check({tag, "_busy"}, 64'(busy), 64'(1));
    while (res_valid !== 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_latency"}, 64'(c), 64'(lat));
    check({tag, "_rd_count"}, 64'(rd_cnt - c0), 64'(t));
    for (int k = 0; k < t; k++) begin
      check({tag, "_rd_a_addr"}, 64'(cap_a[(c0 + k) % 64]), 64'((ab + k) % DEPTH));
      check({tag, "_rd_b_addr"}, 64'(cap_b[(c0 + k) % 64]), 64'((bb + k) % DEPTH));
    end
  endtask

  // Compares the held result against the scoreboard and completes the handshake
  task automatic finish_job(input string tag);
    longint e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hdead;
    res_ready = 1'b1;
    check({tag, "_res_valid"}, 64'(res_valid), 64'(1));
    check({tag, "_res_data"}, 64'(res_data), 64'(e));
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
    check({tag, "_res_data_idle"}, 64'(res_data), 64'(0));
  endtask

  initial begin
    int c0, l;
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < N; i++) begin
        mem_a[a][i] = WIDTH'($urandom);
        mem_b[a][i] = WIDTH'($urandom);
      end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_eng_a", 64'(eng_a), 64'(0));
    check("rst_rd_a_addr", 64'(rd_a_addr), 64'(0));
    rst_n = 1'b1;
    res_ready = 1'b1;

    set_tile(10, 1, 2, 3, 4, 5, 6, 7, 8);
    run_job("basic", 4, 10, 10);
    check("basic_const", 64'(res_data), 64'(70));
    finish_job("basic");

    set_tile(100, 1, 1, 1, 1, 2, 2, 2, 2);
    set_tile(101, 3, 3, 9, 9, 3, 3, 9, 9);
    run_job("tail", 6, 100, 100);
    check("tail_const", 64'(res_data), 64'(26));
    finish_job("tail");

    c0 = rd_cnt;
    run_job("zero", 0, 7, 9);
    finish_job("zero");
    check("zero_no_reads", 64'(rd_cnt - c0), 64'(0));

    set_tile(200, -1, -2, -3, -4, 1, 1, 1, 1);
    res_ready = 1'b0;
    run_job("hold", 4, 200, 200);
    c0 = rd_cnt;
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; len = LEN_W'(4);
      @(posedge clk); #1;
      check("hold_res_data", 64'(res_data), 64'(-10));
      check("hold_busy", 64'(busy), 64'(1));
    end
    finish_job("hold");
    start = 1'b0;
    check("hold_no_reads", 64'(rd_cnt - c0), 64'(0));
    @(posedge clk); #1;
    check("hold_no_second_job", 64'(busy), 64'(0));
    res_ready = 1'b1;

    run_job("wrap", 8, 4095, 30);
    finish_job("wrap");

    start = 1'b1; len = LEN_W'(12); a_base = '0; b_base = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rd_en", 64'(rd_en), 64'(0));
    check("abort_res_valid", 64'(res_valid), 64'(0));
    check("abort_res_data", 64'(res_data), 64'(0));
    check("abort_rd_a_addr", 64'(rd_a_addr), 64'(0));
    check("abort_rd_b_addr", 64'(rd_b_addr), 64'(0));
    check("abort_eng_a", 64'(eng_a), 64'(0));
    check("abort_eng_b", 64'(eng_b), 64'(0));
    rst_n = 1'b1;
    run_job("fresh", 4, 10, 10);
    check("fresh_const", 64'(res_data), 64'(70));
    finish_job("fresh");

    for (int j = 0; j < 4; j++) begin
      l = $urandom_range(1, 40);
      run_job("rand", l, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      finish_job("rand");
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("idle_eng_a", 64'(eng_a), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
